// File: rtl/csa_seq_adder.sv
// Wide add/sub sequencing one 32-bit carry-select slice over WORDS chunks, LS chunk first.
// Latency WORDS+1 edges after accept; result held in DONE until out_ready, no input taken outside IDLE.
module csa_seq_adder #(
  parameter int WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic                  cin,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   sum,
  output logic                  carry,
  output logic                  overflow
);

  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [WORDS-1:0][31:0] r_a;
  logic [WORDS-1:0][31:0] r_b;
  logic [WORDS-1:0][31:0] r_sum;
  logic                   r_carry;
  logic                   r_last;
  logic                   r_ovf;
  logic [IW-1:0]          r_idx;

  logic [32:0]            w_s0;
  logic [32:0]            w_s1;
  logic [32:0]            w_sel;
  logic                   w_accept;
  logic                   w_step;

  // Both candidate chunk sums are formed every cycle; the registered carry picks one.
  assign w_s0  = {1'b0, r_a[r_idx]} + {1'b0, r_b[r_idx]};
  assign w_s1  = {1'b0, r_a[r_idx]} + {1'b0, r_b[r_idx]} + 33'd1;
  assign w_sel = r_carry ? w_s1 : w_s0;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_step   = (r_state == S_RUN) && !r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (r_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      // Subtract is folded into an add of ~b with carry-in forced to 1.
      r_a     <= a;
      r_b     <= op ? ~b : b;
      r_carry <= op ? 1'b1 : cin;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (w_step) begin
      r_sum[r_idx] <= w_sel[31:0];
      r_carry      <= w_sel[32];
      if (r_idx == LAST) begin
        r_last <= 1'b1;
        r_ovf  <= (r_a[WORDS-1][31] == r_b[WORDS-1][31]) &&
                  (w_sel[31] != r_a[WORDS-1][31]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_csa_seq_adder.sv
// Bench for csa_seq_adder: WORDS=2 and WORDS=4 instances against an arithmetic reference model.
module tb_csa_seq_adder;

  logic         clk = 1'b0;
  logic         rst2_n, rst4_n, iv2, iv4, op, cin, ordy;
  logic [127:0] a_in, b_in;
  logic         ir2, ov2, c2, o2, ir4, ov4, c4, o4;
  logic [63:0]  s2;
  logic [127:0] s4;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  csa_seq_adder #(.WORDS(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .in_valid(iv2), .in_ready(ir2), .op(op), .cin(cin),
    .a(a_in[63:0]), .b(b_in[63:0]), .out_valid(ov2), .out_ready(ordy),
    .sum(s2), .carry(c2), .overflow(o2)
  );

  csa_seq_adder #(.WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4), .op(op), .cin(cin),
    .a(a_in), .b(b_in), .out_valid(ov4), .out_ready(ordy),
    .sum(s4), .carry(c4), .overflow(o4)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        op;
    logic        cin;
    logic [63:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain (w+1)-bit arithmetic on the architectural operands.
  function automatic void model(input int w, input logic [127:0] a, input logic [127:0] b,
                                input logic o, input logic ci,
                                output logic [127:0] s, output logic c, output logic v);
    logic [127:0] mask, am, bp;
    logic [128:0] ext;
    mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
    am   = a & mask;
    bp   = (o ? ~b : b) & mask;
    ext  = {1'b0, am} + {1'b0, bp} + 129'(o ? 1'b1 : ci);
    s    = ext[127:0] & mask;
    c    = ext[w];
    v    = (am[w-1] == bp[w-1]) && (s[w-1] != am[w-1]);
  endfunction

  task automatic do_op(input bit sel, input logic [127:0] a, input logic [127:0] b,
                       input logic o, input logic ci, output int lat,
                       output logic [127:0] s, output logic c, output logic v);
    @(negedge clk);
    a_in = a; b_in = b; op = o; cin = ci;
    if (sel) iv4 = 1'b1; else iv2 = 1'b1;
    @(posedge clk);
    #1;
    iv2 = 1'b0; iv4 = 1'b0;
    a_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    op = 1'($urandom()); cin = 1'($urandom());
    lat = 0;
    while (((sel ? ov4 : ov2) == 1'b0) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL out_valid_timeout: got no out_valid within %0d edges", lat);
    end
    s = sel ? s4 : {64'b0, s2};
    c = sel ? c4 : c2;
    v = sel ? o4 : o2;
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
    chk("in_ready_after_handoff", 128'(sel ? ir4 : ir2), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           lat;
    logic [127:0] s, es, ra, rb;
    logic         c, v, ec, ev, seen;
    bit           sel;

    tbl[0] = '{64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h00000001_00000000, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0};
    tbl[2] = '{64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0};
    tbl[3] = '{64'h80000000_00000000, 64'h1, 1'b1, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1};
    tbl[4] = '{64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1};
    tbl[5] = '{64'h1, 64'h2, 1'b0, 1'b1, 64'h4, 1'b0, 1'b0};
    tbl[6] = '{64'h5, 64'h3, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0};

    rst2_n = 1'b0; rst4_n = 1'b0; iv2 = 1'b0; iv4 = 1'b0;
    op = 1'b0; cin = 1'b0; ordy = 1'b0; a_in = '0; b_in = '0;
    #2;
    chk("rst_in_ready2", 128'(ir2), 128'(1));
    chk("rst_out_valid2", 128'(ov2), 128'(0));
    chk("rst_sum2", 128'(s2), 128'(0));
    chk("rst_carry2", 128'(c2), 128'(0));
    chk("rst_ovf2", 128'(o2), 128'(0));
    chk("rst_in_ready4", 128'(ir4), 128'(1));
    chk("rst_sum4", s4, 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst2_n = 1'b1; rst4_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(1'b0, 128'(tbl[i].a), 128'(tbl[i].b), tbl[i].op, tbl[i].cin, lat, s, c, v);
      chk($sformatf("vec%0d_sum", i), s, 128'(tbl[i].s));
      chk($sformatf("vec%0d_carry", i), 128'(c), 128'(tbl[i].c));
      chk($sformatf("vec%0d_ovf", i), 128'(v), 128'(tbl[i].v));
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(3));
    end

    for (int i = 0; i < 40; i++) begin
      sel = i[0];
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i % 8 == 2) rb = ~ra;
      if (i % 8 == 5) rb = ra;
      model(sel ? 128 : 64, ra, rb, i[2], i[1], es, ec, ev);
      do_op(sel, ra, rb, i[2], i[1], lat, s, c, v);
      chk($sformatf("rnd%0d_sum", i), s, es);
      chk($sformatf("rnd%0d_carry", i), 128'(c), 128'(ec));
      chk($sformatf("rnd%0d_ovf", i), 128'(v), 128'(ev));
      chk($sformatf("rnd%0d_latency", i), 128'(lat), 128'(sel ? 5 : 3));
    end

    // Backpressure: result held while out_ready is low, and new requests are ignored.
    ra = 128'h0000_0000_0000_0000_9ABC_DEF0_1234_5678;
    rb = 128'h0000_0000_0000_0000_8765_4321_FEDC_BA98;
    model(64, ra, rb, 1'b0, 1'b1, es, ec, ev);
    @(negedge clk);
    a_in = ra; b_in = rb; op = 1'b0; cin = 1'b1; iv2 = 1'b1;
    @(posedge clk);
    #1;
    iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency", 128'(lat), 128'(3));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iv2 = (k == 2);
      a_in = 128'h1; b_in = 128'h1; op = 1'b0; cin = 1'b0;
      @(posedge clk);
      #1;
      iv2 = 1'b0;
      chk($sformatf("bp%0d_out_valid", k), 128'(ov2), 128'(1));
      chk($sformatf("bp%0d_in_ready", k), 128'(ir2), 128'(0));
      chk($sformatf("bp%0d_sum", k), 128'(s2), es);
      chk($sformatf("bp%0d_carry", k), 128'(c2), 128'(ec));
      chk($sformatf("bp%0d_ovf", k), 128'(o2), 128'(ev));
    end
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
    chk("bp_release_out_valid", 128'(ov2), 128'(0));
    chk("bp_release_in_ready", 128'(ir2), 128'(1));
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ov2) seen = 1'b1;
    end
    chk("bp_request_not_queued", 128'(seen), 128'(0));

    // Reset one cycle into RUN discards the operation.
    @(negedge clk);
    a_in = {4{32'hFFFF_0001}}; b_in = {4{32'h0F0F_0F0F}}; op = 1'b0; cin = 1'b1; iv4 = 1'b1;
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    @(posedge clk);
    #1;
    rst4_n = 1'b0;
    #1;
    chk("midrun_rst_in_ready", 128'(ir4), 128'(1));
    chk("midrun_rst_out_valid", 128'(ov4), 128'(0));
    chk("midrun_rst_sum", s4, 128'(0));
    repeat (2) @(negedge clk);
    rst4_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ov4) seen = 1'b1;
    end
    chk("midrun_rst_no_out_valid", 128'(seen), 128'(0));
    do_op(1'b1, 128'd5, 128'd3, 1'b0, 1'b0, lat, s, c, v);
    chk("post_rst_sum", s, 128'd8);
    chk("post_rst_carry", 128'(c), 128'(0));
    chk("post_rst_ovf", 128'(v), 128'(0));
    chk("post_rst_latency", 128'(lat), 128'(5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
